// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM type and FIFO entry layout for the PS/2 receive path
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    localparam int ENTRY_W = 10;
    localparam int DATA_LSB = 0;
    localparam int PAR_ERR_BIT = 8;
    localparam int FRM_ERR_BIT = 9;
    localparam int PS2_DATA_BITS = 8;
endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: generic first-word-fall-through FIFO, head presented combinationally
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               rd_en,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               empty,
    output logic               full,
    output logic [AW:0]        count
);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic wr_ok, rd_ok;
    assign rd_ok = rd_en && !empty;
    // a full FIFO still accepts a write when the same cycle frees a slot
    assign wr_ok = wr_en && (!full || rd_ok);
    assign empty = count == '0;
    assign full = count == DEPTH_C;
    assign rd_data = empty ? '0 : mem[rp];
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wp] <= wr_data;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            wp <= wr_ok ? wp + 1'b1 : wp;
            rp <= rd_ok ? rp + 1'b1 : rp;
            count <= count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
        end
    end
endmodule

// File: rtl/ps2_rx_buffered.sv
// ps2_rx_buffered: PS/2 receiver with glitch-filtered sampling, watchdog and FWFT byte FIFO
module ps2_rx_buffered
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH = 8,
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             kc,
    input  logic             kd,
    input  logic             rd_en,
    input  logic             err_clr,
    output logic [7:0]       rd_data,
    output logic             rd_par_err,
    output logic             rd_frm_err,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             frame_done,
    output logic             parity_err,
    output logic             overflow,
    output logic             timeout_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES);
    logic [SYNC_STAGES-1:0] kc_s, kd_s;
    logic kc_b, kd_b, kc_f, kc_f_d, fall;
    logic [FW-1:0] flt_cnt;
    logic [WW-1:0] wd_cnt;
    state_t state;
    logic [2:0] bit_cnt;
    logic [PS2_DATA_BITS-1:0] shreg;
    logic par_bit, wr_en, accept, abort;
    logic [ENTRY_W-1:0] wr_data, head;
    assign kc_b = kc_s[SYNC_STAGES-1];
    assign kd_b = kd_s[SYNC_STAGES-1];
    assign fall = kc_f_d & ~kc_f;
    assign abort = state != IDLE && !fall && wd_cnt == WD_MAX;
    assign wr_en = state == STOP && fall;
    assign accept = wr_en && (!full || rd_en);
    always_comb begin
        wr_data = '0;
        wr_data[DATA_LSB +: PS2_DATA_BITS] = shreg;
        wr_data[PAR_ERR_BIT] = ~^{shreg, par_bit};
        wr_data[FRM_ERR_BIT] = ~kd_b;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kc_s <= '1;
            kd_s <= '1;
            kc_f <= 1'b1;
            kc_f_d <= 1'b1;
            flt_cnt <= '0;
        end else begin
            kc_s <= {kc_s[SYNC_STAGES-2:0], kc};
            kd_s <= {kd_s[SYNC_STAGES-2:0], kd};
            kc_f_d <= kc_f;
            kc_f <= (kc_b != kc_f && flt_cnt == FLT_MAX) ? kc_b : kc_f;
            flt_cnt <= (kc_b == kc_f || flt_cnt == FLT_MAX) ? '0 : flt_cnt + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            bit_cnt <= '0;
            shreg <= '0;
            par_bit <= 1'b0;
            wd_cnt <= '0;
        end else begin
            wd_cnt <= (state == IDLE || fall || abort) ? '0 : wd_cnt + 1'b1;
            if (abort) state <= IDLE;
            else if (fall) begin
                case (state)
                    IDLE: begin
                        state <= kd_b ? IDLE : DATA;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        shreg <= {kd_b, shreg[PS2_DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        state <= bit_cnt == 3'(PS2_DATA_BITS - 1) ? PARITY : DATA;
                    end
                    PARITY: begin
                        par_bit <= kd_b;
                        state <= STOP;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            parity_err <= 1'b0;
            overflow <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            frame_done <= accept;
            parity_err <= (accept & wr_data[PAR_ERR_BIT]) | (parity_err & ~err_clr);
            overflow <= (wr_en & ~accept) | (overflow & ~err_clr);
            timeout_err <= abort | (timeout_err & ~err_clr);
        end
    end
    ps2_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(accept),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_data(head),
        .empty(empty),
        .full(full),
        .count(count)
    );
    assign rd_data = head[DATA_LSB +: PS2_DATA_BITS];
    assign rd_par_err = head[PAR_ERR_BIT];
    assign rd_frm_err = head[FRM_ERR_BIT];
endmodule

// File: tb/tb_ps2_rx_buffered.sv
// tb_ps2_rx_buffered: directed and randomized PS/2 frames against a queue-based model
module tb_ps2_rx_buffered;
    localparam int DEPTH = 4;
    localparam int HALF = 20;
    logic clk = 1'b0, rst_n = 1'b0, kc = 1'b1, kd = 1'b1, rd_en = 1'b0, err_clr = 1'b0;
    logic [7:0] rd_data;
    logic rd_par_err, rd_frm_err, empty, full, frame_done, parity_err, overflow, timeout_err;
    logic [2:0] count;
    int checks = 0, failures = 0, fd_pulses = 0, pre;
    logic [9:0] q[$];
    bit m_par, m_ovf, m_to;

    ps2_rx_buffered #(.TIMEOUT_CYCLES(200), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .kc(kc), .kd(kd), .rd_en(rd_en), .err_clr(err_clr),
        .rd_data(rd_data), .rd_par_err(rd_par_err), .rd_frm_err(rd_frm_err),
        .empty(empty), .full(full), .count(count), .frame_done(frame_done),
        .parity_err(parity_err), .overflow(overflow), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (frame_done === 1'b1) fd_pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] head();
        return q.size() > 0 ? q[0] : 10'd0;
    endfunction

    function automatic logic odd_par(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    task automatic check_state(input string tag);
        logic [9:0] h;
        h = head();
        check({tag, ".count"}, 32'(count), q.size());
        check({tag, ".empty"}, empty, q.size() == 0);
        check({tag, ".full"}, full, q.size() == DEPTH);
        check({tag, ".rd_data"}, rd_data, h[7:0]);
        check({tag, ".rd_par_err"}, rd_par_err, h[8]);
        check({tag, ".rd_frm_err"}, rd_frm_err, h[9]);
        check({tag, ".parity_err"}, parity_err, m_par);
        check({tag, ".overflow"}, overflow, m_ovf);
        check({tag, ".timeout_err"}, timeout_err, m_to);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit pop);
        logic [10:0] bits;
        logic [9:0] e;
        bit acc;
        bits = {s, p, d, 1'b0};
        e = {~s, (($countones(d) + int'(p)) % 2) == 0, d};
        for (int i = 0; i < 11; i++) begin
            kd = bits[i];
            repeat (HALF) @(negedge clk);
            kc = 1'b0;
            if (i == 10) begin
                repeat (6) @(negedge clk);
                if (pop && q.size() > 0) check("stop_pop.head", rd_data, q[0][7:0]);
                rd_en = pop;
                @(negedge clk);
                rd_en = 1'b0;
                acc = q.size() < DEPTH || (pop && q.size() > 0);
                if (pop && q.size() > 0) void'(q.pop_front());
                if (acc) begin
                    q.push_back(e);
                    m_par |= e[8];
                end else m_ovf = 1'b1;
                check("frame_done", frame_done, acc);
                check_state("frame");
                repeat (HALF - 7) @(negedge clk);
            end else repeat (HALF) @(negedge clk);
            kc = 1'b1;
        end
        repeat (HALF) @(negedge clk);
    endtask

    task automatic pop_one();
        check("pop.head", rd_data, head() & 10'hff);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        check_state("pop");
    endtask

    task automatic clear_flags();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        {m_par, m_ovf, m_to} = 3'b000;
        check_state("err_clr");
    endtask

    task automatic partial(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            kd = i == 0 ? 1'b0 : 1'($urandom);
            repeat (HALF) @(negedge clk);
            kc = 1'b0;
            repeat (HALF) @(negedge clk);
            kc = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] d;
        repeat (3) @(negedge clk);
        check("reset.frame_done", frame_done, 1'b0);
        check_state("reset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        pop_one();
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        clear_flags();
        send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
        while (q.size() > 0) pop_one();
        pre = fd_pulses;
        for (int k = 1; k <= 5; k++) send_frame(8'(k), odd_par(8'(k)), 1'b1, 1'b0);
        check("fill.fd_pulses", fd_pulses - pre, 4);
        send_frame(8'h06, odd_par(8'h06), 1'b1, 1'b1);
        while (q.size() > 0) pop_one();
        clear_flags();
        pre = fd_pulses;
        partial(4);
        repeat (250) @(negedge clk);
        m_to = 1'b1;
        check_state("timeout");
        check("timeout.fd_pulses", fd_pulses - pre, 0);
        send_frame(8'h5A, odd_par(8'h5A), 1'b1, 1'b0);
        pop_one();
        clear_flags();
        kd = 1'b0;
        kc = 1'b0;
        repeat (2) @(negedge clk);
        kc = 1'b1;
        kd = 1'b1;
        repeat (30) @(negedge clk);
        check_state("glitch");
        d = 8'($urandom);
        send_frame(d, odd_par(d), 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b1, 1'b0);
        partial(5);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        {m_par, m_ovf, m_to} = 3'b000;
        check_state("mid_reset");
        send_frame(8'hA5, odd_par(8'hA5), 1'b1, 1'b0);
        for (int n = 0; n < 40; n++) begin
            d = 8'($urandom);
            send_frame(d, $urandom_range(0, 3) == 0 ? ~odd_par(d) : odd_par(d),
                       $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) pop_one();
            if ($urandom_range(0, 7) == 0) clear_flags();
        end
        while (q.size() > 0) pop_one();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
